// File: rtl/w0rm_core_memory_mp.sv
// Word memory with a read-only instruction fetch port and a byte-enabled bus port, both with a fixed READ_LATENCY.
// Define W0RM_MEM_ADDR_CHECK_EN to reject out-of-range addresses instead of wrapping them into the array.
module w0rm_core_memory_mp #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    INST_WIDTH   = 16,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h20000000),
   parameter int                    DEPTH_WORDS  = 1024,
   parameter int                    READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   inst_addr,
   input  logic                    inst_read,
   input  logic                    inst_valid_in,
   output logic [INST_WIDTH-1:0]   inst_data_out,
   output logic                    inst_valid_out,
   input  logic [ADDR_WIDTH-1:0]   bus_addr,
   input  logic                    bus_read,
   input  logic                    bus_write,
   input  logic                    bus_valid_in,
   input  logic [DATA_WIDTH/8-1:0] bus_byte_en,
   input  logic [DATA_WIDTH-1:0]   bus_data_in,
   output logic [DATA_WIDTH-1:0]   bus_data_out,
   output logic                    bus_valid_out,
   output logic                    bus_error
);
   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int OFF_BITS = $clog2(BYTES);
   localparam int IDX_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int SLICES   = DATA_WIDTH / INST_WIDTH;
   localparam int SEL_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int INST_OFF = $clog2(INST_WIDTH / 8);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0] inst_rel;
   logic [ADDR_WIDTH-1:0] bus_rel;
   logic [IDX_BITS-1:0]   inst_idx;
   logic [IDX_BITS-1:0]   bus_idx;
   logic [SEL_W-1:0]      inst_sel;
   logic                  inst_ok;
   logic                  bus_ok;
   logic                  inst_acc;
   logic                  bus_rd_acc;
   logic                  bus_wr_acc;
   logic                  unused_rel_bits;

   logic [READ_LATENCY-1:0] inst_v_reg;
   logic [READ_LATENCY-1:0] bus_v_reg;
   logic [READ_LATENCY-1:0] bus_err_reg;
   logic [DATA_WIDTH-1:0]   inst_word_reg [READ_LATENCY];
   logic [SEL_W-1:0]        inst_sel_reg  [READ_LATENCY];
   logic [DATA_WIDTH-1:0]   bus_word_reg  [READ_LATENCY];

   assign inst_rel = inst_addr - BASE_ADDR;
   assign bus_rel  = bus_addr - BASE_ADDR;
   assign inst_idx = inst_rel[OFF_BITS +: IDX_BITS];
   assign bus_idx  = bus_rel[OFF_BITS +: IDX_BITS];
   assign inst_sel = (SLICES > 1) ? inst_rel[INST_OFF +: SEL_W] : '0;
   assign unused_rel_bits = ^{inst_rel, bus_rel};

`ifdef W0RM_MEM_ADDR_CHECK_EN
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);
   // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds.
   assign inst_ok = ({1'b0, inst_rel} < MEM_BYTES);
   assign bus_ok  = ({1'b0, bus_rel} < MEM_BYTES);
`else
   assign inst_ok = 1'b1;
   assign bus_ok  = 1'b1;
`endif

   assign inst_acc   = inst_valid_in & inst_read;
   assign bus_rd_acc = bus_valid_in & bus_read;
   assign bus_wr_acc = bus_valid_in & bus_write & bus_ok;

   always_ff @(posedge clk) begin
      if (bus_wr_acc && !reset) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus_byte_en[b]) begin
               mem[bus_idx][8*b +: 8] <= bus_data_in[8*b +: 8];
            end
         end
      end
   end

   // Data stages only load behind a valid token, so the last stage holds the most recent response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_v_reg  <= '0;
         bus_v_reg   <= '0;
         bus_err_reg <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            inst_word_reg[s] <= '0;
            inst_sel_reg[s]  <= '0;
            bus_word_reg[s]  <= '0;
         end
      end else begin
         inst_v_reg[0] <= inst_acc;
         bus_v_reg[0]  <= bus_rd_acc;
         if (inst_acc) begin
            inst_word_reg[0] <= inst_ok ? mem[inst_idx] : '0;
            inst_sel_reg[0]  <= inst_sel;
         end
         if (bus_rd_acc) begin
            bus_word_reg[0] <= bus_ok ? mem[bus_idx] : '0;
            bus_err_reg[0]  <= ~bus_ok;
         end
         for (int s = 1; s < READ_LATENCY; s++) begin
            inst_v_reg[s] <= inst_v_reg[s-1];
            bus_v_reg[s]  <= bus_v_reg[s-1];
            if (inst_v_reg[s-1]) begin
               inst_word_reg[s] <= inst_word_reg[s-1];
               inst_sel_reg[s]  <= inst_sel_reg[s-1];
            end
            if (bus_v_reg[s-1]) begin
               bus_word_reg[s] <= bus_word_reg[s-1];
               bus_err_reg[s]  <= bus_err_reg[s-1];
            end
         end
      end
   end

   assign inst_valid_out = inst_v_reg[READ_LATENCY-1];
   assign inst_data_out  = inst_word_reg[READ_LATENCY-1][inst_sel_reg[READ_LATENCY-1]*INST_WIDTH +: INST_WIDTH];
   assign bus_valid_out  = bus_v_reg[READ_LATENCY-1];
   assign bus_data_out   = bus_word_reg[READ_LATENCY-1];
   assign bus_error      = bus_v_reg[READ_LATENCY-1] & bus_err_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_w0rm_core_memory_mp.sv
// Bench for w0rm_core_memory_mp: directed vector table, randomized traffic against a word-array model, and an in-flight reset.
// Expectations follow W0RM_MEM_ADDR_CHECK_EN when the bench is built with that macro.
`timescale 1ns/1ps
module tb_w0rm_core_memory_mp;
   localparam int          DW    = 32;
   localparam int          IW    = 16;
   localparam int          AW    = 32;
   localparam int          DEPTH = 1024;
   localparam int          LAT   = 3;
   localparam logic [31:0] BASE  = 32'h20000000;
   localparam logic        Y     = 1'b1;
   localparam logic        N     = 1'b0;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] inst_addr;
   logic          inst_read;
   logic          inst_valid_in;
   logic [IW-1:0] inst_data_out;
   logic          inst_valid_out;
   logic [AW-1:0] bus_addr;
   logic          bus_read;
   logic          bus_write;
   logic          bus_valid_in;
   logic [3:0]    bus_byte_en;
   logic [DW-1:0] bus_data_in;
   logic [DW-1:0] bus_data_out;
   logic          bus_valid_out;
   logic          bus_error;

   w0rm_core_memory_mp #(
      .DATA_WIDTH(DW), .INST_WIDTH(IW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
      .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .inst_addr(inst_addr), .inst_read(inst_read), .inst_valid_in(inst_valid_in),
      .inst_data_out(inst_data_out), .inst_valid_out(inst_valid_out),
      .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write), .bus_valid_in(bus_valid_in),
      .bus_byte_en(bus_byte_en), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
      .bus_valid_out(bus_valid_out), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        bv, br, bw;
      logic [31:0] ba, bd;
      logic [3:0]  be;
      logic        iv, ir;
      logic [31:0] ia;
      logic        bchk;
      logic [31:0] bexp;
      logic        berr;
      logic        ichk;
      logic [15:0] iexp;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] model_mem [DEPTH];
   // Expected responses keyed by the tick (mod 8) after which they must be visible.
   logic        slot_iv [8];
   logic [15:0] slot_id [8];
   logic        slot_bv [8];
   logic [31:0] slot_bd [8];
   logic        slot_be [8];
   logic [15:0] last_id;
   logic [31:0] last_bd;
   int          tick_n;
   int          vectors;
   int          miscompares;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at tick %0d: got %0h, expected %0h", name, tick_n, act, exp);
      end
   endtask

   function automatic logic model_in_range(input logic [31:0] a);
`ifdef W0RM_MEM_ADDR_CHECK_EN
      return (a - BASE) < 32'(DEPTH * 4);
`else
      return (a == a);
`endif
   endfunction

   function automatic int model_idx(input logic [31:0] a);
      logic [31:0] rel;
      rel = a - BASE;
      return int'((rel / 4) % DEPTH);
   endfunction

   function automatic logic [31:0] rnd_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) return 32'h1FFFFFF0 + 32'($urandom_range(0, 15));
      if (r == 1) return 32'h20001000 + 32'($urandom_range(0, 3));
      return BASE + 32'($urandom_range(0, 127));
   endfunction

   function automatic void add(input logic bv, br, bw, input logic [31:0] ba, bd, input logic [3:0] be,
                               input logic iv, ir, input logic [31:0] ia,
                               input logic bchk, input logic [31:0] bexp, input logic berr,
                               input logic ichk, input logic [15:0] iexp);
      vec_t v;
      v.bv = bv; v.br = br; v.bw = bw; v.ba = ba; v.bd = bd; v.be = be;
      v.iv = iv; v.ir = ir; v.ia = ia;
      v.bchk = bchk; v.bexp = bexp; v.berr = berr; v.ichk = ichk; v.iexp = iexp;
      tbl.push_back(v);
   endfunction

   task automatic clear_slots();
      for (int s = 0; s < 8; s++) begin
         slot_iv[s] = 1'b0; slot_id[s] = '0; slot_bv[s] = 1'b0; slot_bd[s] = '0; slot_be[s] = 1'b0;
      end
   endtask

   task automatic tick();
      int s;
      @(posedge clk);
      #1;
      tick_n++;
      s = tick_n % 8;
      check("inst_valid_out", 32'(inst_valid_out), 32'(slot_iv[s]));
      if (slot_iv[s]) last_id = slot_id[s];
      check("inst_data_out", 32'(inst_data_out), 32'(last_id));
      check("bus_valid_out", 32'(bus_valid_out), 32'(slot_bv[s]));
      if (slot_bv[s]) last_bd = slot_bd[s];
      check("bus_data_out", bus_data_out, last_bd);
      check("bus_error", 32'(bus_error), 32'(slot_bv[s] & slot_be[s]));
      slot_iv[s] = 1'b0;
      slot_bv[s] = 1'b0;
   endtask

   // Drive one cycle of requests, predict its responses, then advance one clock and check.
   task automatic cycle(input logic bv, br, bw, input logic [31:0] ba, bd, input logic [3:0] be,
                        input logic iv, ir, input logic [31:0] ia,
                        input logic bchk, input logic [31:0] bexp, input logic berr,
                        input logic ichk, input logic [15:0] iexp);
      int          slot;
      int          sl;
      logic        ok;
      logic [31:0] w;
      bus_valid_in = bv; bus_read = br; bus_write = bw; bus_addr = ba; bus_data_in = bd; bus_byte_en = be;
      inst_valid_in = iv; inst_read = ir; inst_addr = ia;
      slot = (tick_n + LAT) % 8;
      if (!reset) begin
         if (iv && ir) begin
            w  = model_in_range(ia) ? model_mem[model_idx(ia)] : 32'h0;
            sl = int'(((ia - BASE) >> 1) & 32'h1);
            slot_iv[slot] = 1'b1;
            slot_id[slot] = ichk ? iexp : ((sl == 1) ? w[31:16] : w[15:0]);
         end
         ok = model_in_range(ba);
         if (bv && br) begin
            w = ok ? model_mem[model_idx(ba)] : 32'h0;
            slot_bv[slot] = 1'b1;
            slot_bd[slot] = bchk ? bexp : w;
            slot_be[slot] = bchk ? berr : !ok;
         end
         if (bv && bw && ok) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) model_mem[model_idx(ba)][8*b +: 8] = bd[8*b +: 8];
            end
         end
      end
      tick();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(N, N, N, 32'h0, 32'h0, 4'h0, N, N, 32'h0, N, 32'h0, N, N, 16'h0);
   endtask

   task automatic check_reset_outputs();
      check("rst inst_valid_out", 32'(inst_valid_out), 32'h0);
      check("rst inst_data_out", 32'(inst_data_out), 32'h0);
      check("rst bus_valid_out", 32'(bus_valid_out), 32'h0);
      check("rst bus_data_out", bus_data_out, 32'h0);
      check("rst bus_error", 32'(bus_error), 32'h0);
   endtask

   // Assert reset mid-cycle, hold it for n clocks while offering traffic that must be ignored.
   task automatic do_reset(input int n);
      reset = 1'b1;
      #1;
      check_reset_outputs();
      clear_slots();
      last_id = '0;
      last_bd = '0;
      for (int k = 0; k < n; k++)
         cycle(Y, Y, Y, BASE, 32'hFFFFFFFF, 4'hF, Y, Y, BASE, N, 32'h0, N, N, 16'h0);
      reset = 1'b0;
   endtask

   initial begin
      logic        bv, br, bw, iv, ir;
      logic [31:0] ba, bd, ia;
      logic [3:0]  be;
      int          op;
      logic        chk_en;

      vectors = 0; miscompares = 0; tick_n = 0;
      last_id = '0; last_bd = '0;
      clear_slots();
      reset = 1'b1;
      bus_valid_in = 1'b0; bus_read = 1'b0; bus_write = 1'b0; bus_addr = '0; bus_data_in = '0; bus_byte_en = '0;
      inst_valid_in = 1'b0; inst_read = 1'b0; inst_addr = '0;
      #2;
      check_reset_outputs();
      idle(2);
      reset = 1'b0;

`ifdef W0RM_MEM_ADDR_CHECK_EN
      chk_en = 1'b1;
`else
      chk_en = 1'b0;
`endif
      //  bv br bw  bus addr       bus data      be    iv ir fetch addr    bchk bexp          berr ichk iexp
      add(Y, N, Y, 32'h20000000, 32'hDEADBEEF, 4'hF, N, N, 32'h0,        N, 32'h0,        N, N, 16'h0);
      add(N, N, N, 32'h0,        32'h0,        4'h0, Y, Y, 32'h20000000, N, 32'h0,        N, Y, 16'hBEEF);
      add(N, N, N, 32'h0,        32'h0,        4'h0, Y, Y, 32'h20000002, N, 32'h0,        N, Y, 16'hDEAD);
      add(Y, N, Y, 32'h20000010, 32'hAAAAAAAA, 4'hF, N, N, 32'h0,        N, 32'h0,        N, N, 16'h0);
      add(Y, N, Y, 32'h20000010, 32'h11223344, 4'h5, N, N, 32'h0,        N, 32'h0,        N, N, 16'h0);
      add(Y, Y, N, 32'h20000010, 32'h0,        4'h0, N, N, 32'h0,        Y, 32'hAA22AA44, N, N, 16'h0);
      add(Y, N, Y, 32'h20000004, 32'h0000CAFE, 4'hF, N, N, 32'h0,        N, 32'h0,        N, N, 16'h0);
      add(Y, N, Y, 32'h20000004, 32'h00000001, 4'hF, Y, Y, 32'h20000004, N, 32'h0,        N, Y, 16'hCAFE);
      add(N, N, N, 32'h0,        32'h0,        4'h0, Y, Y, 32'h20000004, N, 32'h0,        N, Y, 16'h0001);
      add(Y, Y, Y, 32'h20000000, 32'h12345678, 4'hF, N, N, 32'h0,        Y, 32'hDEADBEEF, N, N, 16'h0);
      add(Y, N, Y, 32'h20000008, 32'h08080808, 4'hF, N, N, 32'h0,        N, 32'h0,        N, N, 16'h0);
      add(Y, N, Y, 32'h2000000C, 32'h0C0C0C0C, 4'hF, N, N, 32'h0,        N, 32'h0,        N, N, 16'h0);
      add(Y, Y, N, 32'h20000000, 32'h0,        4'h0, N, N, 32'h0,        Y, 32'h12345678, N, N, 16'h0);
      add(Y, Y, N, 32'h20000004, 32'h0,        4'h0, N, N, 32'h0,        Y, 32'h00000001, N, N, 16'h0);
      add(Y, Y, N, 32'h20000008, 32'h0,        4'h0, N, N, 32'h0,        Y, 32'h08080808, N, N, 16'h0);
      add(Y, Y, N, 32'h2000000C, 32'h0,        4'h0, N, N, 32'h0,        Y, 32'h0C0C0C0C, N, N, 16'h0);
      add(Y, Y, N, 32'h20000007, 32'h0,        4'h0, Y, Y, 32'h20000006, Y, 32'h00000001, N, Y, 16'h0000);
      add(N, Y, N, 32'h20000000, 32'h0,        4'h0, N, Y, 32'h20000000, N, 32'h0,        N, N, 16'h0);
      add(Y, N, N, 32'h20000000, 32'h0,        4'h0, Y, N, 32'h20000000, N, 32'h0,        N, N, 16'h0);
      add(Y, N, Y, 32'h1FFFFFFC, 32'h5A5A5A5A, 4'hF, N, N, 32'h0,        N, 32'h0,        N, N, 16'h0);
      add(Y, Y, N, 32'h1FFFFFFC, 32'h0,        4'h0, Y, Y, 32'h1FFFFFFE, Y,
          chk_en ? 32'h0 : 32'h5A5A5A5A, chk_en, Y, chk_en ? 16'h0 : 16'h5A5A);

      for (int i = 0; i < tbl.size(); i++)
         cycle(tbl[i].bv, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd, tbl[i].be,
               tbl[i].iv, tbl[i].ir, tbl[i].ia,
               tbl[i].bchk, tbl[i].bexp, tbl[i].berr, tbl[i].ichk, tbl[i].iexp);
      idle(LAT);

      // Give every word the random traffic can reach a defined value.
      for (int w = 0; w < 32; w++)
         cycle(Y, N, Y, BASE + 32'(4*w), $urandom, 4'hF, N, N, 32'h0, N, 32'h0, N, N, 16'h0);
      for (int w = DEPTH-4; w < DEPTH; w++)
         cycle(Y, N, Y, BASE + 32'(4*w), $urandom, 4'hF, N, N, 32'h0, N, 32'h0, N, N, 16'h0);

      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 3);
         bv = ($urandom_range(0, 7) != 0);
         br = (op == 1 || op == 3);
         bw = (op >= 2);
         ba = rnd_addr();
         bd = $urandom;
         be = 4'($urandom);
         iv = ($urandom_range(0, 7) != 0);
         ir = ($urandom_range(0, 3) != 0);
         ia = rnd_addr();
         cycle(bv, br, bw, ba, bd, be, iv, ir, ia, N, 32'h0, N, N, 16'h0);
      end
      idle(LAT);

      // Reads in flight when reset hits must never come out; memory must survive the reset.
      cycle(Y, Y, N, BASE, 32'h0, 4'h0, Y, Y, BASE + 32'h2, N, 32'h0, N, N, 16'h0);
      do_reset(2);
      idle(LAT + 1);
      cycle(Y, Y, N, BASE, 32'h0, 4'h0, Y, Y, BASE, N, 32'h0, N, N, 16'h0);
      idle(LAT);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/w0rm_core_memory_mp.md
W0RM_CORE_MEMORY_MP -- requirements
Module: w0rm_core_memory_mp

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32: bus data width in bits, a multiple of 16.
REQ-002 SHALL provide parameter INST_WIDTH, default 16: instruction fetch width; DATA_WIDTH is a multiple of INST_WIDTH.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 32: byte-address width for both ports.
REQ-004 SHALL provide parameter BASE_ADDR, default 32'h20000000: byte address of word 0.
REQ-005 SHALL provide parameter DEPTH_WORDS, default 1024: memory depth in DATA_WIDTH words, a power of two.
REQ-006 SHALL provide parameter READ_LATENCY, default 1, legal range 1..4: cycles from accepted read to valid_out.
REQ-007 SHALL have clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have inst_addr, input, ADDR_WIDTH: instruction byte address.
REQ-010 SHALL have inst_read and inst_valid_in, inputs, 1 each: a fetch is accepted when both are high.
REQ-011 SHALL have inst_data_out, output, INST_WIDTH; and inst_valid_out, output, 1.
REQ-012 SHALL have bus_addr, input, ADDR_WIDTH; bus_read, bus_write, bus_valid_in, inputs, 1 each.
REQ-013 SHALL have bus_byte_en, input, DATA_WIDTH/8: per-byte write strobes.
REQ-014 SHALL have bus_data_in, input, DATA_WIDTH; bus_data_out, output, DATA_WIDTH; bus_valid_out, output, 1.
REQ-015 SHALL have bus_error, output, 1: out-of-range access flag, aligned with bus_valid_out timing.

Function
REQ-016 SHALL compute word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); byte-offset bits are ignored for bus accesses.
REQ-017 SHALL select the inst_data_out slice from the addressed word using the INST_WIDTH-aligned offset bits of inst_addr; slice 0 is the least significant.
REQ-018 SHALL, on an accepted fetch, drive inst_valid_out high with the data exactly READ_LATENCY cycles later, for exactly one cycle per fetch.
REQ-019 SHALL accept one fetch and one bus access per cycle with no stall; back-to-back requests yield back-to-back responses in issue order.
REQ-020 SHALL, on bus_valid_in && bus_write, update only the bytes with bus_byte_en set, at the accepting clock edge.
REQ-021 SHALL, on bus_valid_in && bus_read, return the word READ_LATENCY cycles later with bus_valid_out high for one cycle; writes alone produce no bus_valid_out.
REQ-022 SHALL, when bus_read and bus_write are both set, perform the write and return the pre-write word (read-before-write).
REQ-023 SHALL, on a fetch and a bus write to the same word in the same cycle, return the pre-write data to the instruction port.
REQ-024 SHALL, on a request issued the cycle after a write to the same word, return the post-write data.
REQ-025 SHALL hold inst_data_out and bus_data_out at their last value while the matching valid_out is low.
REQ-026 SHALL keep per-port valid pipelines as shift registers of depth READ_LATENCY; no internal FSM beyond them.

Reset
REQ-027 SHALL, while reset is high, force inst_valid_out, bus_valid_out, bus_error to 0 and inst_data_out, bus_data_out to 0.
REQ-028 SHALL discard all in-flight reads on reset assertion; no valid_out for them after release.
REQ-029 SHALL NOT clear or alter memory contents on reset; writes presented during reset are ignored.
REQ-030 SHALL accept requests starting on the first rising edge after reset deasserts.

Configuration
REQ-031 SHALL, with macro W0RM_MEM_ADDR_CHECK_EN defined, treat addresses below BASE_ADDR or at/above BASE_ADDR + DEPTH_WORDS*DATA_WIDTH/8 as out of range: writes suppressed, reads return 0 with bus_error high alongside bus_valid_out; out-of-range fetches return 0.
REQ-032 SHALL, without W0RM_MEM_ADDR_CHECK_EN, wrap word index modulo DEPTH_WORDS and tie bus_error to 0.

Verification
REQ-033 Write 32'hDEADBEEF to 32'h20000000 with byte_en 4'hF, then fetch 32'h20000000 and 32'h20000002 -> inst_data_out 16'hBEEF then 16'hDEAD, each READ_LATENCY cycles after issue.
REQ-034 Write 32'h11223344 to 32'h20000010 with byte_en 4'b0101 over prior 32'hAAAAAAAA, then bus read -> bus_data_out 32'hAA22AA44.
REQ-035 Same-cycle bus write 32'h00000001 and fetch to 32'h20000004 holding 32'h0000CAFE -> inst_data_out 16'hCAFE; fetch next cycle -> 16'h0001.
REQ-036 READ_LATENCY=3, four back-to-back bus reads of 0x20000000..0x2000000C -> four consecutive valid_out cycles starting 3 cycles after first issue, in order.
REQ-037 Issue a read at READ_LATENCY=2, assert reset one cycle later for 2 cycles -> no bus_valid_out; memory word unchanged on read after release.
REQ-038 With W0RM_MEM_ADDR_CHECK_EN, write then read 32'h1FFFFFFC -> bus_data_out 0, bus_error 1; without it, the same address aliases to word DEPTH_WORDS-1 and returns the written data with bus_error 0.
